// File: rtl/mcu_output_arbiter_if.sv
// mcu_output_arbiter_if: requester words in, one handshaked word channel out to the MCU
interface mcu_output_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 16
);
    localparam int GW = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      cts;
    logic [DATA_W-1:0]         output_data;
    logic                      rts;
    logic [GW-1:0]             grant_id;
    logic                      timeout;
    logic [7:0]                drop_count;
    modport master (
        input  req_valid, req_data, cts,
        output req_ready, output_data, rts, grant_id, timeout, drop_count
    );
    modport slave (
        output req_valid, req_data, cts,
        input  req_ready, output_data, rts, grant_id, timeout, drop_count
    );
endinterface

// File: rtl/mcu_output_arbiter.sv
// mcu_output_arbiter: round-robin share of the MCU output word channel with 4-phase rts/cts
module mcu_output_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_W      = 16,
    parameter int CTS_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    mcu_output_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int TW = $clog2(CTS_TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(CTS_TIMEOUT - 1);
    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;
    state_t            state;
    logic [TW-1:0]     timer;
    logic [GW-1:0]     rr_ptr;
    logic [GW-1:0]     win;
    logic              any;
    logic              stall;
    logic [DATA_W-1:0] slot [NUM_REQ];
    function automatic logic [GW-1:0] wrap(input int v);
        return GW'(v % NUM_REQ);
    endfunction
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign slot[g] = bus.req_data[g*DATA_W +: DATA_W];
    end
    // Scan farthest-first so the nearest valid index after rr_ptr is the one left standing
    always_comb begin
        win = '0;
        any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (bus.req_valid[wrap(int'(rr_ptr) + k)]) begin
                win = wrap(int'(rr_ptr) + k);
                any = 1'b1;
            end
    end
    assign bus.req_ready = (state == IDLE && enable && reset && any) ? NUM_REQ'(1) << win : '0;
    // SEND waits for cts to rise, RELEASE waits for it to fall
    assign stall = (state == SEND) ? !bus.cts : bus.cts;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            timer           <= '0;
            rr_ptr          <= GW'(NUM_REQ - 1);
            bus.output_data <= '0;
            bus.rts         <= 1'b0;
            bus.grant_id    <= '0;
            bus.timeout     <= 1'b0;
            bus.drop_count  <= '0;
        end else if (enable) begin
            bus.timeout <= 1'b0;
            if (state == IDLE) begin
                if (any) begin
                    bus.output_data <= slot[win];
                    bus.grant_id    <= win;
                    rr_ptr          <= win;
                    bus.rts         <= 1'b1;
                    timer           <= '0;
                    state           <= SEND;
                end
            end else if (!stall) begin
                bus.rts <= 1'b0;
                timer   <= '0;
                state   <= (state == SEND) ? RELEASE : IDLE;
            end else if (timer == LIMIT) begin
                bus.rts        <= 1'b0;
                bus.timeout    <= 1'b1;
                bus.drop_count <= bus.drop_count + 8'(bus.drop_count != 8'hFF);
                state          <= IDLE;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end
endmodule
